regfile_wb_arbiter: RTL and testbench

- Write-back controller for the 4x16 register file; sole driver of its RegWrite/RD/WriteData inputs.
- Arbitrates two write-back requesters (ALU result, memory load) onto the single write port with round-robin fairness.
- Keeps a per-register pending-write scoreboard so decode can stall on RAW hazards.
- Sits between the execute/memory stages and the register file.

---
 rtl/regfile_wb_arbiter_pkg.sv | 19 +
 rtl/rr_arbiter2.sv | 36 +++
 rtl/regfile_wb_arbiter.sv | 120 ++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants and payload types for the register-file write-back path.
package regfile_wb_arbiter_pkg;

    localparam int unsigned DATA_W  = 16;
    localparam int unsigned ADDR_W  = 2;
    localparam int unsigned NREGS   = 1 << ADDR_W;

    // Requester indices on the write-back arbiter
    localparam int unsigned NREQ    = 2;
    localparam int unsigned REQ_ALU = 0;
    localparam int unsigned REQ_MEM = 1;

    // One write-back request payload
    typedef struct packed {
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin grant; the favored index flips to the other side on every accept.
module rr_arbiter2
    import regfile_wb_arbiter_pkg::*;
(
    input  logic            Clock,
    input  logic            ResetN,
    input  logic [NREQ-1:0] req,
    input  logic            accept,
    output logic [NREQ-1:0] grant_c
);

    // Index that wins when both requesters are valid
    logic prio;

    // Grant: lone requester wins, contention goes to prio; nothing granted in reset
    always_comb begin
        grant_c = '0;
        if (ResetN) begin
            if (req[REQ_ALU] && req[REQ_MEM]) begin
                grant_c[prio] = 1'b1;
            end else begin
                grant_c = req;
            end
        end
    end

    // Pointer advances only on an accepted handshake
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            prio <= 1'(REQ_ALU);
        end else if (accept) begin
            prio <= grant_c[REQ_ALU] ? 1'(REQ_MEM) : 1'(REQ_ALU);
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-back controller: arbitrates ALU/load results onto the register-file
// write port and tracks outstanding writers for RAW hazard detection.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
(
    input  logic              Clock,
    input  logic              ResetN,
    input  logic              AluValid,
    output logic              AluReady,
    input  logic [ADDR_W-1:0] AluRd,
    input  logic [DATA_W-1:0] AluData,
    input  logic              MemValid,
    output logic              MemReady,
    input  logic [ADDR_W-1:0] MemRd,
    input  logic [DATA_W-1:0] MemData,
    input  logic              IssueValid,
    input  logic [ADDR_W-1:0] IssueRd,
    input  logic [ADDR_W-1:0] RS,
    input  logic [ADDR_W-1:0] RT,
    output logic              HazardRS,
    output logic              HazardRT,
    output logic              RegWrite,
    output logic [ADDR_W-1:0] RD,
    output logic [DATA_W-1:0] WriteData,
    output logic [NREGS-1:0]  Busy,
    output logic              Error
);

    logic [NREQ-1:0]  req_c;
    logic [NREQ-1:0]  grant_c;
    logic             accept_c;
    wb_req_t          win_c;
    logic             issue_set_c;
    logic [NREGS-1:0] busy_next_c;
    logic             error_next_c;

    // Requester vector in package index order
    always_comb begin
        req_c          = '0;
        req_c[REQ_ALU] = AluValid;
        req_c[REQ_MEM] = MemValid;
    end

    rr_arbiter2 u_rr (
        .Clock   (Clock),
        .ResetN  (ResetN),
        .req     (req_c),
        .accept  (accept_c),
        .grant_c (grant_c)
    );

    assign AluReady = grant_c[REQ_ALU];
    assign MemReady = grant_c[REQ_MEM];
    assign accept_c = |grant_c;

    // Winner payload; grant is one-hot so a simple select suffices
    always_comb begin
        win_c.rd   = AluRd;
        win_c.data = AluData;
        if (grant_c[REQ_MEM]) begin
            win_c.rd   = MemRd;
            win_c.data = MemData;
        end
    end

    // Register-file write port; R0 writes complete the handshake silently
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            RegWrite  <= 1'b0;
            RD        <= '0;
            WriteData <= '0;
        end else if (accept_c) begin
            RegWrite  <= (win_c.rd != '0);
            RD        <= win_c.rd;
            WriteData <= win_c.data;
        end else begin
            RegWrite  <= 1'b0;
        end
    end

    // Scoreboard next state: commit clears, issue sets, set wins on collision
    always_comb begin
        issue_set_c = IssueValid && (IssueRd != '0);
        busy_next_c = Busy;
        if (RegWrite) begin
            busy_next_c[RD] = 1'b0;
        end
        if (issue_set_c) begin
            busy_next_c[IssueRd] = 1'b1;
        end
        busy_next_c[0] = 1'b0;
    end

    // Protocol errors: commit without an outstanding writer, or a second
    // writer issued while the first has not retired on this same edge
    always_comb begin
        error_next_c = Error;
        if (RegWrite && !Busy[RD]) begin
            error_next_c = 1'b1;
        end
        if (issue_set_c && Busy[IssueRd] && !(RegWrite && (RD == IssueRd))) begin
            error_next_c = 1'b1;
        end
    end

    // Scoreboard and sticky error state
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            Busy  <= '0;
            Error <= 1'b0;
        end else begin
            Busy  <= busy_next_c;
            Error <= error_next_c;
        end
    end

    assign HazardRS = Busy[RS];
    assign HazardRT = Busy[RT];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed vector table, reset corner case,
// then randomized traffic against a cycle-level reference model.
module tb_regfile_wb_arbiter;
    import regfile_wb_arbiter_pkg::*;

    logic              Clock = 1'b0;
    logic              ResetN;
    logic              AluValid, MemValid, IssueValid;
    logic              AluReady, MemReady;
    logic [ADDR_W-1:0] AluRd, MemRd, IssueRd, RS, RT, RD;
    logic [DATA_W-1:0] AluData, MemData, WriteData;
    logic              HazardRS, HazardRT, RegWrite, Error;
    logic [NREGS-1:0]  Busy;

    int n_checks = 0;
    int n_fail   = 0;

    regfile_wb_arbiter dut (
        .Clock      (Clock),
        .ResetN     (ResetN),
        .AluValid   (AluValid),
        .AluReady   (AluReady),
        .AluRd      (AluRd),
        .AluData    (AluData),
        .MemValid   (MemValid),
        .MemReady   (MemReady),
        .MemRd      (MemRd),
        .MemData    (MemData),
        .IssueValid (IssueValid),
        .IssueRd    (IssueRd),
        .RS         (RS),
        .RT         (RT),
        .HazardRS   (HazardRS),
        .HazardRT   (HazardRT),
        .RegWrite   (RegWrite),
        .RD         (RD),
        .WriteData  (WriteData),
        .Busy       (Busy),
        .Error      (Error)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Directed vector: inputs for one cycle, expected combinational outputs
    // during that cycle, expected registered outputs after its edge.
    typedef struct {
        logic              av;
        logic [ADDR_W-1:0] ard;
        logic [DATA_W-1:0] adat;
        logic              mv;
        logic [ADDR_W-1:0] mrd;
        logic [DATA_W-1:0] mdat;
        logic              iv;
        logic [ADDR_W-1:0] ird;
        logic [ADDR_W-1:0] rs;
        logic [ADDR_W-1:0] rt;
        logic              e_ar, e_mr, e_hrs, e_hrt;
        logic              e_rw;
        logic [ADDR_W-1:0] e_rd;
        logic [DATA_W-1:0] e_wd;
        logic [NREGS-1:0]  e_busy;
        logic              e_err;
    } vec_t;

    localparam int unsigned NVEC = 18;
    vec_t vecs [NVEC];

    // Reference model state (value after the most recent edge)
    logic              m_rw;
    logic [ADDR_W-1:0] m_rd;
    logic [DATA_W-1:0] m_wd;
    logic              m_busy [NREGS];
    logic              m_err;
    int                m_turn;   // requester that wins the next contention
    logic              x_ar, x_mr;

    task automatic model_reset();
        m_rw = 1'b0; m_rd = '0; m_wd = '0; m_err = 1'b0; m_turn = 0;
        for (int i = 0; i < int'(NREGS); i++) m_busy[i] = 1'b0;
    endtask

    task automatic model_comb();
        x_ar = AluValid && (!MemValid || m_turn == 0);
        x_mr = MemValid && (!AluValid || m_turn == 1);
    endtask

    // Advance the model across one rising edge using the current inputs
    task automatic model_step();
        logic nb [NREGS];
        for (int i = 0; i < int'(NREGS); i++) nb[i] = m_busy[i];
        if (m_rw) begin
            if (!m_busy[m_rd]) m_err = 1'b1;
            nb[m_rd] = 1'b0;
        end
        if (IssueValid && IssueRd != 0) begin
            if (m_busy[IssueRd] && !(m_rw && m_rd == IssueRd)) m_err = 1'b1;
            nb[IssueRd] = 1'b1;
        end
        if (x_ar) begin
            m_rd = AluRd; m_wd = AluData; m_rw = (AluRd != 0); m_turn = 1;
        end else if (x_mr) begin
            m_rd = MemRd; m_wd = MemData; m_rw = (MemRd != 0); m_turn = 0;
        end else begin
            m_rw = 1'b0;
        end
        for (int i = 0; i < int'(NREGS); i++) m_busy[i] = nb[i];
    endtask

    function automatic logic [NREGS-1:0] model_busy_vec();
        logic [NREGS-1:0] v;
        for (int i = 0; i < int'(NREGS); i++) v[i] = m_busy[i];
        return v;
    endfunction

    task automatic idle_inputs();
        AluValid = 1'b0; AluRd = '0; AluData = '0;
        MemValid = 1'b0; MemRd = '0; MemData = '0;
        IssueValid = 1'b0; IssueRd = '0; RS = '0; RT = '0;
    endtask

    task automatic do_reset();
        ResetN = 1'b0;
        @(posedge Clock); #1;
        ResetN = 1'b1;
        model_reset();
    endtask

    initial begin
        // RD,WD after-edge columns carry the held values where no accept occurs
        vecs[0]  = '{1'b0,2'd0,16'h0000, 1'b0,2'd0,16'h0000, 1'b1,2'd3, 2'd3,2'd0, 1'b0,1'b0,1'b0,1'b0, 1'b0,2'd0,16'h0000,4'b1000,1'b0};
        vecs[1]  = '{1'b1,2'd3,16'h0005, 1'b0,2'd0,16'h0000, 1'b0,2'd0, 2'd3,2'd0, 1'b1,1'b0,1'b1,1'b0, 1'b1,2'd3,16'h0005,4'b1000,1'b0};
        vecs[2]  = '{1'b0,2'd0,16'h0000, 1'b0,2'd0,16'h0000, 1'b0,2'd0, 2'd3,2'd0, 1'b0,1'b0,1'b1,1'b0, 1'b0,2'd3,16'h0005,4'b0000,1'b0};
        vecs[3]  = '{1'b0,2'd0,16'h0000, 1'b0,2'd0,16'h0000, 1'b0,2'd0, 2'd3,2'd0, 1'b0,1'b0,1'b0,1'b0, 1'b0,2'd3,16'h0005,4'b0000,1'b0};
        vecs[4]  = '{1'b0,2'd0,16'h0000, 1'b1,2'd0,16'hFFFF, 1'b0,2'd0, 2'd0,2'd0, 1'b0,1'b1,1'b0,1'b0, 1'b0,2'd0,16'hFFFF,4'b0000,1'b0};
        vecs[5]  = '{1'b0,2'd0,16'h0000, 1'b0,2'd0,16'h0000, 1'b1,2'd2, 2'd0,2'd2, 1'b0,1'b0,1'b0,1'b0, 1'b0,2'd0,16'hFFFF,4'b0100,1'b0};
        vecs[6]  = '{1'b1,2'd2,16'h1234, 1'b0,2'd0,16'h0000, 1'b0,2'd0, 2'd0,2'd2, 1'b1,1'b0,1'b0,1'b1, 1'b1,2'd2,16'h1234,4'b0100,1'b0};
        vecs[7]  = '{1'b0,2'd0,16'h0000, 1'b0,2'd0,16'h0000, 1'b1,2'd2, 2'd0,2'd2, 1'b0,1'b0,1'b0,1'b1, 1'b0,2'd2,16'h1234,4'b0100,1'b0};
        vecs[8]  = '{1'b1,2'd2,16'h4321, 1'b0,2'd0,16'h0000, 1'b0,2'd0, 2'd0,2'd2, 1'b1,1'b0,1'b0,1'b1, 1'b1,2'd2,16'h4321,4'b0100,1'b0};
        vecs[9]  = '{1'b0,2'd0,16'h0000, 1'b0,2'd0,16'h0000, 1'b0,2'd0, 2'd0,2'd2, 1'b0,1'b0,1'b0,1'b1, 1'b0,2'd2,16'h4321,4'b0000,1'b0};
        vecs[10] = '{1'b0,2'd0,16'h0000, 1'b1,2'd0,16'h0000, 1'b0,2'd0, 2'd0,2'd0, 1'b0,1'b1,1'b0,1'b0, 1'b0,2'd0,16'h0000,4'b0000,1'b0};
        vecs[11] = '{1'b0,2'd0,16'h0000, 1'b0,2'd0,16'h0000, 1'b1,2'd2, 2'd0,2'd0, 1'b0,1'b0,1'b0,1'b0, 1'b0,2'd0,16'h0000,4'b0100,1'b0};
        vecs[12] = '{1'b0,2'd0,16'h0000, 1'b0,2'd0,16'h0000, 1'b1,2'd1, 2'd0,2'd0, 1'b0,1'b0,1'b0,1'b0, 1'b0,2'd0,16'h0000,4'b0110,1'b0};
        vecs[13] = '{1'b1,2'd2,16'hAAAA, 1'b1,2'd1,16'h1111, 1'b0,2'd0, 2'd1,2'd2, 1'b1,1'b0,1'b1,1'b1, 1'b1,2'd2,16'hAAAA,4'b0110,1'b0};
        vecs[14] = '{1'b1,2'd2,16'hAAAA, 1'b1,2'd1,16'h1111, 1'b0,2'd0, 2'd1,2'd2, 1'b0,1'b1,1'b1,1'b1, 1'b1,2'd1,16'h1111,4'b0010,1'b0};
        vecs[15] = '{1'b1,2'd2,16'hAAAA, 1'b1,2'd1,16'h1111, 1'b0,2'd0, 2'd1,2'd2, 1'b1,1'b0,1'b1,1'b0, 1'b1,2'd2,16'hAAAA,4'b0000,1'b0};
        vecs[16] = '{1'b1,2'd2,16'hAAAA, 1'b1,2'd1,16'h1111, 1'b0,2'd0, 2'd1,2'd2, 1'b0,1'b1,1'b0,1'b0, 1'b1,2'd1,16'h1111,4'b0000,1'b1};
        vecs[17] = '{1'b0,2'd0,16'h0000, 1'b0,2'd0,16'h0000, 1'b0,2'd0, 2'd1,2'd2, 1'b0,1'b0,1'b0,1'b0, 1'b0,2'd1,16'h1111,4'b0000,1'b1};

        // Reset held two cycles with a pending ALU request
        idle_inputs();
        ResetN = 1'b0;
        AluValid = 1'b1; AluRd = 2'd1; AluData = 16'h00AA;
        repeat (2) @(posedge Clock);
        #4;
        check("reset AluReady", 32'(AluReady), 32'd0);
        check("reset RegWrite", 32'(RegWrite), 32'd0);
        check("reset Busy",     32'(Busy),     32'd0);
        check("reset Error",    32'(Error),    32'd0);
        check("reset RD",       32'(RD),       32'd0);
        check("reset WriteData",32'(WriteData),32'd0);
        idle_inputs();
        @(posedge Clock); #1;
        ResetN = 1'b1;

        // Directed table
        for (int v = 0; v < int'(NVEC); v++) begin
            AluValid = vecs[v].av;  AluRd = vecs[v].ard; AluData = vecs[v].adat;
            MemValid = vecs[v].mv;  MemRd = vecs[v].mrd; MemData = vecs[v].mdat;
            IssueValid = vecs[v].iv; IssueRd = vecs[v].ird;
            RS = vecs[v].rs; RT = vecs[v].rt;
            #4;
            check($sformatf("vec%0d AluReady", v), 32'(AluReady), 32'(vecs[v].e_ar));
            check($sformatf("vec%0d MemReady", v), 32'(MemReady), 32'(vecs[v].e_mr));
            check($sformatf("vec%0d HazardRS", v), 32'(HazardRS), 32'(vecs[v].e_hrs));
            check($sformatf("vec%0d HazardRT", v), 32'(HazardRT), 32'(vecs[v].e_hrt));
            @(posedge Clock); #1;
            check($sformatf("vec%0d RegWrite", v),  32'(RegWrite),  32'(vecs[v].e_rw));
            check($sformatf("vec%0d RD", v),        32'(RD),        32'(vecs[v].e_rd));
            check($sformatf("vec%0d WriteData", v), 32'(WriteData), 32'(vecs[v].e_wd));
            check($sformatf("vec%0d Busy", v),      32'(Busy),      32'(vecs[v].e_busy));
            check($sformatf("vec%0d Error", v),     32'(Error),     32'(vecs[v].e_err));
        end

        // Asynchronous reset while a write pulse is on the port
        idle_inputs();
        IssueValid = 1'b1; IssueRd = 2'd3;
        @(posedge Clock); #1;
        idle_inputs();
        AluValid = 1'b1; AluRd = 2'd3; AluData = 16'h0007;
        @(posedge Clock); #1;
        check("midrst pre RegWrite", 32'(RegWrite), 32'd1);
        #2;
        ResetN = 1'b0;
        #1;
        check("midrst RegWrite", 32'(RegWrite), 32'd0);
        check("midrst Busy",     32'(Busy),     32'd0);
        check("midrst Error",    32'(Error),    32'd0);
        check("midrst AluReady", 32'(AluReady), 32'd0);
        AluRd = 2'd0; MemValid = 1'b1; MemRd = 2'd0;
        @(posedge Clock); #1;
        ResetN = 1'b1;
        #3;
        check("postrst AluReady", 32'(AluReady), 32'd1);
        check("postrst MemReady", 32'(MemReady), 32'd0);
        @(posedge Clock); #1;
        idle_inputs();
        do_reset();

        // Randomized traffic against the model, with periodic resets
        for (int cyc = 0; cyc < 800; cyc++) begin
            if (cyc % 97 == 96) begin
                idle_inputs();
                do_reset();
            end
            if (!AluValid || x_ar) begin
                AluValid = 1'($urandom_range(0, 1));
                AluRd    = ADDR_W'($urandom_range(0, NREGS - 1));
                AluData  = DATA_W'($urandom);
            end
            if (!MemValid || x_mr) begin
                MemValid = 1'($urandom_range(0, 1));
                MemRd    = ADDR_W'($urandom_range(0, NREGS - 1));
                MemData  = DATA_W'($urandom);
            end
            IssueValid = ($urandom_range(0, 2) == 0);
            IssueRd    = ADDR_W'($urandom_range(0, NREGS - 1));
            RS         = ADDR_W'($urandom_range(0, NREGS - 1));
            RT         = ADDR_W'($urandom_range(0, NREGS - 1));
            #4;
            model_comb();
            check($sformatf("rnd%0d AluReady", cyc),  32'(AluReady),  32'(x_ar));
            check($sformatf("rnd%0d MemReady", cyc),  32'(MemReady),  32'(x_mr));
            check($sformatf("rnd%0d HazardRS", cyc),  32'(HazardRS),  32'(m_busy[RS]));
            check($sformatf("rnd%0d HazardRT", cyc),  32'(HazardRT),  32'(m_busy[RT]));
            check($sformatf("rnd%0d RegWrite", cyc),  32'(RegWrite),  32'(m_rw));
            check($sformatf("rnd%0d RD", cyc),        32'(RD),        32'(m_rd));
            check($sformatf("rnd%0d WriteData", cyc), 32'(WriteData), 32'(m_wd));
            check($sformatf("rnd%0d Busy", cyc),      32'(Busy),      32'(model_busy_vec()));
            check($sformatf("rnd%0d Error", cyc),     32'(Error),     32'(m_err));
            model_step();
            @(posedge Clock); #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
